// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the ID-stage immediate generator:
//   - RV32/RV64 base opcodes the decoder recognises
//   - imm_fmt_t : 3-bit immediate-format tag carried with every result
//   - pipe_state_t : {main_valid, skid_valid} encoding of the output pipeline
// ---------------------------------------------------------------------------
package id_pkg;

  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] IMM      = 7'b0010011;
  localparam logic [6:0] IMM32    = 7'b0011011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP32     = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  // Bit 1 = main register full, bit 0 = skid entry full.
  // 2'b01 (skid full, main empty) can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_t;

endpackage

// File: rtl/id_imm_decode.sv
// ---------------------------------------------------------------------------
// id_imm_decode
// Purely combinational immediate extraction for one instruction word.
// Ports:
//   inst    in  32    raw instruction
//   pc      in  XLEN  PC of inst
//   imm     out XLEN  extended immediate (0 for NONE formats)
//   fmt     out 3     imm_fmt_t format tag
//   target  out XLEN  pc + imm, wrapping at XLEN
//   illegal out 1     opcode outside the decoded set
// ---------------------------------------------------------------------------
module id_imm_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [31:0] imm32;
  imm_fmt_t    fmt_sel;

  assign opc = inst[6:0];

  // Every format is first built as a 32-bit value whose bit 31 is the sign.
  // The Z format keeps bit 31 clear, so the common sign extension below
  // becomes a zero extension for CSR immediates.
  always_comb begin
    imm32   = '0;
    fmt_sel = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      LUI, AUIPC: begin
        imm32   = {inst[31:12], 12'b0};
        fmt_sel = FMT_U;
      end
      IMM, LOAD, JALR: begin
        imm32   = {{20{inst[31]}}, inst[31:20]};
        fmt_sel = FMT_I;
      end
      IMM32: begin
        if (RV64) begin
          imm32   = {{20{inst[31]}}, inst[31:20]};
          fmt_sel = FMT_I;
        end else begin
          illegal = 1'b1;
        end
      end
      STORE: begin
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt_sel = FMT_S;
      end
      BRANCH: begin
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt_sel = FMT_B;
      end
      JAL: begin
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt_sel = FMT_J;
      end
      SYSTEM: begin
        // funct3[2] selects the CSR*I forms carrying a 5-bit uimm in rs1.
        if (inst[14]) begin
          imm32   = {27'b0, inst[19:15]};
          fmt_sel = FMT_Z;
        end
      end
      MISC_MEM, OP: begin
        fmt_sel = FMT_NONE;
      end
      OP32: begin
        if (!RV64) illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm    = XLEN'($signed(imm32));
  assign fmt    = fmt_sel;
  assign target = pc + imm;

endmodule

// File: rtl/id_imm_gen.sv
// ---------------------------------------------------------------------------
// id_imm_gen
// Pipelined immediate generator for the ID stage: one combinational decode
// on the input path, a main output register and a one-entry skid buffer so
// that in_ready never depends combinationally on out_ready.
// Ports:
//   clk, rst_n          clock (rising) / async active-low reset
//   flush               synchronous kill of both entries, blocks capture
//   in_valid/in_ready   upstream handshake (in_ready is a flop output)
//   in_inst, in_pc      instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_imm, out_fmt, out_target, out_pc, out_illegal   registered result
// ---------------------------------------------------------------------------
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("id_imm_gen: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm, dec_target;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  id_imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_decode (
    .inst    (in_inst),
    .pc      (in_pc),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .target  (dec_target),
    .illegal (dec_illegal)
  );

  pipe_state_t     state_reg, state_next;
  logic [XLEN-1:0] main_imm_reg, main_target_reg, main_pc_reg;
  logic [2:0]      main_fmt_reg;
  logic            main_illegal_reg;
  logic [XLEN-1:0] skid_imm_reg, skid_target_reg, skid_pc_reg;
  logic [2:0]      skid_fmt_reg;
  logic            skid_illegal_reg;

  logic accept, drain;
  logic load_main_dec, load_main_skid, load_skid;

  assign out_valid = state_reg[1];
  assign in_ready  = ~state_reg[0];
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next    = ST_ONE;
            load_main_dec = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            load_main_dec = 1'b1;
          end else if (accept) begin
            state_next = ST_FULL;
            load_skid  = 1'b1;
          end else if (drain) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm_reg     <= '0;
      main_target_reg  <= '0;
      main_pc_reg      <= '0;
      main_fmt_reg     <= FMT_NONE;
      main_illegal_reg <= 1'b0;
    end else if (load_main_dec) begin
      main_imm_reg     <= dec_imm;
      main_target_reg  <= dec_target;
      main_pc_reg      <= in_pc;
      main_fmt_reg     <= dec_fmt;
      main_illegal_reg <= dec_illegal;
    end else if (load_main_skid) begin
      main_imm_reg     <= skid_imm_reg;
      main_target_reg  <= skid_target_reg;
      main_pc_reg      <= skid_pc_reg;
      main_fmt_reg     <= skid_fmt_reg;
      main_illegal_reg <= skid_illegal_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_reg     <= '0;
      skid_target_reg  <= '0;
      skid_pc_reg      <= '0;
      skid_fmt_reg     <= FMT_NONE;
      skid_illegal_reg <= 1'b0;
    end else if (load_skid) begin
      skid_imm_reg     <= dec_imm;
      skid_target_reg  <= dec_target;
      skid_pc_reg      <= in_pc;
      skid_fmt_reg     <= dec_fmt;
      skid_illegal_reg <= dec_illegal;
    end
  end

  assign out_imm     = main_imm_reg;
  assign out_fmt     = main_fmt_reg;
  assign out_target  = main_target_reg;
  assign out_pc      = main_pc_reg;
  assign out_illegal = main_illegal_reg;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (state_reg != 2'b01)
        else $error("id_imm_gen: skid entry full while main register empty");
    end
  end
`endif

endmodule

// File: tb/tb_id_imm_gen.sv
module tb_id_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [63:0] pc64 = '0;
  logic [31:0] pc32;

  assign pc32 = pc64[31:0];

  // XLEN=32 instance
  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_imm, a_target, a_pc;
  logic [2:0]  a_fmt;
  // XLEN=64, RV64=1 instance
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [63:0] b_imm, b_target, b_pc;
  logic [2:0]  b_fmt;
  // XLEN=64, RV64=0 instance
  logic        c_in_ready, c_out_valid, c_illegal;
  logic [63:0] c_imm, c_target, c_pc;
  logic [2:0]  c_fmt;

  id_imm_gen #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(pc32),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_imm),
    .out_fmt(a_fmt), .out_target(a_target), .out_pc(a_pc), .out_illegal(a_illegal)
  );

  id_imm_gen #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(pc64),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_imm),
    .out_fmt(b_fmt), .out_target(b_target), .out_pc(b_pc), .out_illegal(b_illegal)
  );

  id_imm_gen #(.XLEN(64), .RV64(1'b0)) dut64n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_inst(in_inst), .in_pc(pc64),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_imm),
    .out_fmt(c_fmt), .out_target(c_target), .out_pc(c_pc), .out_illegal(c_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    pc64     = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_imm", a_imm, 0);
    chk("rst_fmt", a_fmt, 0);
    chk("rst_target", a_target, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_illegal", a_illegal, 0);
    chk("rst64_imm", b_imm, 0);
    rst_n = 1'b1;
    step();

    // ---------------- basic extraction (out_ready=1) ----------------
    send(32'h12345037, 64'h0);
    $display("LUI 12345037: imm=%h fmt=%0d", a_imm, a_fmt);
    chk("lui_valid", a_out_valid, 1);
    chk("lui_imm", a_imm, 32'h12345000);
    chk("lui_fmt", a_fmt, 4);

    send(32'hFFF00093, 64'h0);
    $display("ADDI FFF00093: imm=%h fmt=%0d", a_imm, a_fmt);
    chk("addi_imm", a_imm, 32'hFFFFFFFF);
    chk("addi_fmt", a_fmt, 1);

    send(32'h0020A423, 64'h0);
    $display("SW 0020A423: imm=%h fmt=%0d", a_imm, a_fmt);
    chk("sw_imm", a_imm, 32'h00000008);
    chk("sw_fmt", a_fmt, 2);

    step();
    chk("idle_drained", a_out_valid, 0);

    in_valid = 1'b1;
    in_inst  = 32'hFE000EE3;
    pc64     = 64'h100;
    #2;
    chk("beq_pre_edge_valid", a_out_valid, 0);
    step();
    in_valid = 1'b0;
    $display("BEQ FE000EE3 @100: imm=%h target=%h fmt=%0d", a_imm, a_target, a_fmt);
    chk("beq_valid", a_out_valid, 1);
    chk("beq_imm", a_imm, 32'hFFFFFFFC);
    chk("beq_target", a_target, 32'h000000FC);
    chk("beq_fmt", a_fmt, 3);
    chk("beq_pc", a_pc, 32'h100);

    send(32'h00001017, 64'h200);
    $display("AUIPC 00001017 @200: imm=%h target=%h", a_imm, a_target);
    chk("auipc_imm", a_imm, 32'h00001000);
    chk("auipc_target", a_target, 32'h00001200);

    send(32'h3002D073, 64'h0);
    $display("CSRRWI 3002D073: imm=%h fmt=%0d", a_imm, a_fmt);
    chk("csrrwi_imm", a_imm, 32'h5);
    chk("csrrwi_fmt", a_fmt, 6);

    send(32'h00000073, 64'h0);
    $display("ECALL: fmt=%0d illegal=%0d", a_fmt, a_illegal);
    chk("ecall_fmt", a_fmt, 0);
    chk("ecall_illegal", a_illegal, 0);

    send(32'h0000000F, 64'h0);
    $display("FENCE: illegal=%0d", a_illegal);
    chk("fence_illegal", a_illegal, 0);

    send(32'hFFFFF07F, 64'h0);
    $display("opcode 7F: illegal=%0d imm=%h", a_illegal, a_imm);
    chk("bad_illegal", a_illegal, 1);
    chk("bad_imm", a_imm, 0);
    chk("bad_fmt", a_fmt, 0);

    // ---------------- XLEN=64 ----------------
    send(32'h80000037, 64'h1000);
    $display("LUI 80000037 x64: imm=%h target=%h", b_imm, b_target);
    chk("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
    chk("lui64_target", b_target, 64'hFFFFFFFF80001000);
    chk("lui32_imm", a_imm, 32'h80000000);

    send(32'hFFF0809B, 64'h0);
    $display("ADDIW FFF0809B: rv64 imm=%h ill=%0d, rv64=0 ill=%0d", b_imm, b_illegal, c_illegal);
    chk("addiw64_imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("addiw64_fmt", b_fmt, 1);
    chk("addiw64_illegal", b_illegal, 0);
    chk("addiw_norv64_illegal", c_illegal, 1);
    chk("addiw_norv64_imm", c_imm, 0);
    chk("addiw32_illegal", a_illegal, 1);

    send(32'h00B50533, 64'h0);  // ADDW-style OP-32 word (opcode 0111011 below)
    send(32'h00B5053B, 64'h0);
    $display("ADDW: rv64 ill=%0d, rv64=0 ill=%0d", b_illegal, c_illegal);
    chk("op32_rv64_illegal", b_illegal, 0);
    chk("op32_norv64_illegal", c_illegal, 1);

    step();
    chk("pre_bp_empty", a_out_valid, 0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    send(32'h00100093, 64'h10);
    $display("BP A: valid=%0d imm=%h in_ready=%0d", a_out_valid, a_imm, a_in_ready);
    chk("bp_a_imm", a_imm, 1);
    chk("bp_a_in_ready", a_in_ready, 1);

    send(32'h00200093, 64'h14);
    $display("BP B: imm=%h in_ready=%0d", a_imm, a_in_ready);
    chk("bp_b_hold_imm", a_imm, 1);
    chk("bp_b_hold_pc", a_pc, 32'h10);
    chk("bp_b_in_ready", a_in_ready, 0);

    in_valid = 1'b1;
    in_inst  = 32'h00300093;
    pc64     = 64'h18;
    step();
    $display("BP C stalled: imm=%h in_ready=%0d", a_imm, a_in_ready);
    chk("bp_c_stall_imm", a_imm, 1);
    chk("bp_c_in_ready", a_in_ready, 0);
    step();
    chk("bp_c_stall2_imm", a_imm, 1);
    chk("bp_c_stall2_valid", a_out_valid, 1);

    out_ready = 1'b1;
    step();
    $display("BP release: imm=%h in_ready=%0d", a_imm, a_in_ready);
    chk("bp_out_b_imm", a_imm, 2);
    chk("bp_out_b_pc", a_pc, 32'h14);
    chk("bp_release_in_ready", a_in_ready, 1);

    step();
    $display("BP out C: imm=%h", a_imm);
    chk("bp_out_c_imm", a_imm, 3);

    in_inst = 32'h00400093;
    pc64    = 64'h1C;
    step();
    in_valid = 1'b0;
    $display("BP out D: imm=%h pc=%h", a_imm, a_pc);
    chk("bp_out_d_imm", a_imm, 4);
    chk("bp_out_d_pc", a_pc, 32'h1C);

    step();
    chk("bp_done_valid", a_out_valid, 0);

    // ---------------- flush in FULL with concurrent in_valid ----------------
    out_ready = 1'b0;
    send(32'h00500093, 64'h20);
    send(32'h00600093, 64'h24);
    chk("fl_full_in_ready", a_in_ready, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00700093;
    pc64     = 64'h28;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    $display("flush FULL: valid=%0d in_ready=%0d", a_out_valid, a_in_ready);
    chk("fl_full_valid", a_out_valid, 0);
    chk("fl_full_in_ready_after", a_in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_full_no_ghost", a_out_valid, 0);

    // ---------------- flush in ONE with accept possible ----------------
    send(32'h00800093, 64'h30);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h00900093;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    $display("flush ONE: valid=%0d", a_out_valid);
    chk("fl_one_valid", a_out_valid, 0);
    step();
    chk("fl_one_no_ghost", a_out_valid, 0);

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready = 1'b0;
    send(32'h00A00093, 64'h40);
    send(32'h00B00093, 64'h44);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0d in_ready=%0d imm=%h", a_out_valid, a_in_ready, a_imm);
    chk("arst_valid", a_out_valid, 0);
    chk("arst_in_ready", a_in_ready, 1);
    chk("arst_imm", a_imm, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_stays_empty", a_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_imm_gen.md
# id_imm_gen

Parametrised, pipelined immediate generator for the ID stage. Replaces the purely combinational sign-extender. Adds:
- XLEN-generic extension for RV32 and RV64.
- An immediate-format tag and a CSR zero-extended immediate.
- An illegal-opcode flag and a precomputed `pc + imm` target.
- A registered valid/ready output with a one-entry skid buffer, so the ID stage can stall without a combinational ready path.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Legal values are 32 and 64; any other value is an elaboration error.
- `RV64`, (XLEN==64): enables the OP-IMM-32 opcode (0011011). With `RV64`=0 that opcode is flagged illegal.

Ports:
- `clk`  in  1: pipeline clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `flush`  in  1: synchronous pipeline kill, ID-stage redirect.
- `in_valid`  in  1: instruction present upstream.
- `in_ready`  out  1: block accepts this cycle. Registered.
- `in_inst`  in  32: raw instruction word.
- `in_pc`  in  XLEN: PC of `in_inst`.
- `out_valid`  out  1: result registers hold a valid entry.
- `out_ready`  in  1: downstream accepts.
- `out_imm`  out  XLEN: extended immediate.
- `out_fmt`  out  3: format tag. Values: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- `out_target`  out  XLEN: `out_pc + out_imm`, truncated to XLEN.
- `out_pc`  out  XLEN: PC passed through.
- `out_illegal`  out  1: opcode not in the decoded set.

## Operation
Format selection is by opcode `inst[6:0]`:
- LUI, AUIPC: U format, `{inst[31:12], 12'b0}` sign-extended from bit 31 to XLEN.
- OP-IMM, LOAD, JALR, OP-IMM-32 (RV64 only): I format, `inst[31:20]` sign-extended.
- STORE: S format, `{inst[31:25], inst[11:7]}` sign-extended.
- BRANCH: B format, `{inst[31], inst[7], inst[30:25], inst[11:8], 0}` sign-extended.
- JAL: J format, `{inst[31], inst[19:12], inst[20], inst[30:21], 0}` sign-extended.
- SYSTEM with `funct3[2]`=1 (CSRRWI, CSRRSI, CSRRCI): Z format, `inst[19:15]` zero-extended.
- SYSTEM with `funct3[2]`=0: NONE, imm=0, not illegal.
- MISC-MEM (FENCE), OP, OP-32 (RV64 only): NONE, imm=0, not illegal.
- Any other opcode: NONE, imm=0, `out_illegal`=1.
- I-format shifts are not special-cased. The shamt field stays inside `out_imm`, and the ALU masks it.
- `out_target` is computed for every entry. The consumer uses it only for B, J and AUIPC.

Pipeline is a main output register plus one skid entry:
- Main register holds `out_*`; `out_valid` means it is full.
- Accept happens when `in_valid && in_ready`. The decoded result goes to the main register if it is empty or draining this cycle (`out_ready`). Otherwise it goes to the skid entry.
- Drain happens when `out_valid && out_ready`. If the skid entry is full, it moves into the main register on the same edge.
- `in_ready` = !skid_valid, taken from a flop.

State is {main_valid, skid_valid}, with three legal states:
- EMPTY (0,0)
- ONE (1,0)
- FULL (1,1)
- (0,1) is unreachable; assert on it.

Flush:
- `flush`=1 clears both valid bits at the edge and discards any accept in that cycle.
- `in_ready`=1 the following cycle.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `out_*` after edge N.
- Throughput is 1 per cycle while `out_ready`=1.
- After `out_ready` drops, one further instruction is absorbed into the skid entry. `in_ready` falls the cycle after the skid entry fills and rises the cycle after it empties.
- When `out_valid`=1 and `out_ready`=0, `out_*` must stay stable.
- Reset values: `out_valid`=0, `in_ready`=1, `out_imm`/`out_target`/`out_pc`=0, `out_fmt`=NONE, `out_illegal`=0, skid entry cleared.
- Reset mid-stream drops all entries immediately and asynchronously.
- `flush` together with `in_valid`: flush wins, and nothing is captured.
- `flush` while FULL: both entries are lost, and the state goes to EMPTY.
- Simultaneous accept and drain in state ONE: state stays ONE, and the main register takes the new entry.

## Structure
- Shared package `id_pkg` holds:
  - opcode localparams (LUI, AUIPC, IMM, IMM32, LOAD, STORE, BRANCH, JAL, JALR, SYSTEM, MISC_MEM, OP, OP32)
  - the `imm_fmt_t` 3-bit enum
- Sub-module `id_imm_decode` is purely combinational: it takes inst and pc and produces imm, fmt, target and illegal. It is instantiated once on the input path.
- The pipeline/skid logic stays in `id_imm_gen`.

## Test plan
- Basic extraction (XLEN=32):
  - LUI 0x12345037 → imm 0x12345000, fmt U.
  - ADDI 0xFFF00093 → 0xFFFFFFFF, fmt I.
  - SW 0x0020A423 → 0x00000008, fmt S.
- BEQ 0xFE000EE3 at pc 0x100 → imm 0xFFFFFFFC, target 0x000000FC, fmt B, output one cycle after accept.
- CSRRWI 0x3002D073 → imm 0x5, fmt Z. Opcode 0x7F → illegal=1, imm 0.
- XLEN=64:
  - LUI 0x80000037 → 0xFFFFFFFF80000000.
  - ADDIW 0xFFF0809B → 0xFFFFFFFFFFFFFFFF, fmt I.
  - With RV64=0, the same ADDIW word → illegal.
- Backpressure:
  - Stream 4 instructions while `out_ready`=0 from cycle 1. The second is held in the skid entry, `in_ready`=0 after it, and `out_*` stay stable.
  - Release `out_ready`: all 4 emerge in order with no loss or duplication.
- Flush in state FULL with a concurrent `in_valid` → `out_valid`=0 next cycle, `in_ready`=1, and the dropped instruction never appears.
